// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared types and constants for the conditional-execution stage
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational evaluation of an ARMv4 condition field against NZCV
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       cond_ex
);

  logic ge;

  assign ge = (flags.n == flags.v);

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      COND_EQ: cond_ex = flags.z;
      COND_NE: cond_ex = ~flags.z;
      COND_CS: cond_ex = flags.c;
      COND_CC: cond_ex = ~flags.c;
      COND_MI: cond_ex = flags.n;
      COND_PL: cond_ex = ~flags.n;
      COND_VS: cond_ex = flags.v;
      COND_VC: cond_ex = ~flags.v;
      COND_HI: cond_ex = flags.c & ~flags.z;
      COND_LS: cond_ex = ~flags.c | flags.z;
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = ~ge;
      COND_GT: cond_ex = ~flags.z & ge;
      COND_LE: cond_ex = flags.z | ~ge;
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV register, condition gating of write controls; COND_STATS_EN adds retire/squash counters
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       En,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt
`endif
);

    flags_t flags_q;
    logic   commit;

    cond_check u_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (CondEx)
    );

    assign commit   = En & CondEx;
    assign PCSrc    = PCS  & commit;
    assign RegWrite = RegW & commit;
    assign MemWrite = MemW & commit;
    assign Flags    = flags_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else if (commit) begin
            if (FlagW[FLAGW_NZ]) begin
                flags_q.n <= ALUFlags[3];
                flags_q.z <= ALUFlags[2];
            end
            if (FlagW[FLAGW_CV]) begin
                flags_q.c <= ALUFlags[1];
                flags_q.v <= ALUFlags[0];
            end
        end
    end

`ifdef COND_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ExecCnt   <= '0;
            SquashCnt <= '0;
        end else if (En) begin
            if (CondEx) begin
                if (ExecCnt != CNT_MAX) ExecCnt <= ExecCnt + 1'b1;
            end else begin
                if (SquashCnt != CNT_MAX) SquashCnt <= SquashCnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution stage directly downstream of the main instruction decoder in the single-cycle ARMv4 datapath. It holds the architectural NZCV flag register and evaluates the instruction's condition field against the stored flags. It also gates the decoder's write-class controls (PC source, register write, memory write) so that an instruction whose condition fails leaves no architectural side effects. Outputs feed the PC mux, register file and data memory.

## Interface
Parameters:
- CNT_W, 16, width of the retire/squash counters (used only when COND_STATS_EN is defined)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- En  in  1  instruction retires this cycle; 0 = core stalled
- Cond  in  4  condition field, Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle
- FlagW  in  2  flag-write request from decoder: [1] = update N,Z; [0] = update C,V
- PCS  in  1  decoder/PC-logic request to redirect PC
- RegW  in  1  decoder register-write request
- MemW  in  1  decoder memory-write request
- PCSrc  out  1  gated PC redirect
- RegWrite  out  1  gated register write
- MemWrite  out  1  gated memory write
- CondEx  out  1  condition passed for the current instruction
- Flags  out  4  current registered {N,Z,C,V}
- ExecCnt  out  CNT_W  instructions retired with CondEx=1 (COND_STATS_EN only)
- SquashCnt  out  CNT_W  instructions retired with CondEx=0 (COND_STATS_EN only)

## Operation
- CondEx is combinational from Cond and registered Flags (never from ALUFlags):
  - EQ 0000: Z; NE 0001: !Z; CS 0010: C; CC 0011: !C; MI 0100: N; PL 0101: !N; VS 0110: V; VC 0111: !V
  - HI 1000: C&!Z; LS 1001: !C|Z; GE 1010: N==V; LT 1011: N!=V; GT 1100: !Z&(N==V); LE 1101: Z|(N!=V)
  - AL 1110: 1; NV 1111: 0 (ARMv4 "never")
- Gated outputs are combinational:
  - PCSrc = PCS & CondEx & En
  - RegWrite = RegW & CondEx & En
  - MemWrite = MemW & CondEx & En
- Flag register update at the rising edge, only when En & CondEx:
  - FlagW[1]=1: N,Z <= ALUFlags[3:2]
  - FlagW[0]=1: C,V <= ALUFlags[1:0]
  - Halves are independent. FlagW=00 holds all flags.
- Stall: En=0 blocks all flag updates, forces all three gated writes to 0, and holds the counters.
- A failed condition never updates flags, even with FlagW≠00 (e.g. CMPNE with Z=1).

## Timing
- Reset (sync, highest priority): Flags=0000, ExecCnt=0, SquashCnt=0.
  - With Flags=0000: CondEx follows Cond (EQ→0, NE→1, AL→1, NV→0).
- Latency:
  - Flag update is visible on Flags and CondEx in the cycle after the writing instruction.
  - Same-cycle ALUFlags never influence CondEx; this removes the combinational loop through the ALU.
- Reset asserted in the same cycle as En & CondEx & FlagW: reset wins; Flags=0000 next cycle.
- Back-to-back flag writers: each sees the flags left by its predecessor.

## Configuration
- COND_STATS_EN defined: ExecCnt and SquashCnt exist.
  - On each edge with En=1 and no reset: ExecCnt+1 if CondEx, else SquashCnt+1.
  - Both counters saturate at 2^CNT_W−1 and do not wrap.
  - Cleared only by reset.
- Not defined: counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package cond_pkg:
  - cond_e enum of the 16 condition encodings
  - flags_t packed struct {n,z,c,v}
  - FLAGW_NZ / FLAGW_CV bit-index constants
- Sub-module cond_check: purely combinational (Cond, flags_t) → CondEx.
- cond_unit holds the flag register, write gating and optional counters.

## Test plan
- Reset, then Cond=0000 (EQ), PCS=RegW=MemW=1, En=1 → CondEx=0, all gated outputs 0, Flags=0000.
- FlagW=11, Cond=1110, ALUFlags=0100, En=1 → next cycle Flags=0100; then Cond=0000 → CondEx=1, RegWrite=RegW.
- Flags=0100, FlagW=01, ALUFlags=1011 → next Flags=0111 (N,Z held; C,V updated); then Cond=1000 (HI) → CondEx=0.
- Flags=0100, Cond=0001 (NE), FlagW=11, ALUFlags=0000 → CondEx=0, Flags stay 0100; En=0 with Cond=1110, FlagW=11 → no change, all gated outputs 0.
- Sweep all 16 Cond × 16 Flags values against a reference model; Cond=1111 → CondEx=0 always.
- COND_STATS_EN, CNT_W=4: 20 retires with AL → ExecCnt saturates at 15; 3 with NV → SquashCnt=3; reset → both 0.
